// File: rtl/result_display_driver_pkg.sv
// Shared types and constants for the result display driver: FSM states,
// digit codes and the active-low seven-segment table.
package result_display_driver_pkg;

   localparam int unsigned VAL_W  = 8;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BCD_W  = 12;
   localparam int unsigned DD_W   = BCD_W + VAL_W;
   localparam int unsigned SEG_W  = 7;
   localparam int unsigned AN_W   = 4;
   localparam int unsigned ITER_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_HEXLD = 2'd2
   } state_e;

   typedef struct packed {
      logic             blank;
      logic [NIB_W-1:0] nib;
   } digit_t;

   localparam digit_t DIGIT_BLANK = '{blank: 1'b1, nib: 4'h0};
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // {g,f,e,d,c,b,a}, active-low, standard hex glyphs 0..F
   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic digit_t mk_digit(input logic [NIB_W-1:0] n);
      return '{blank: 1'b0, nib: n};
   endfunction

   function automatic logic [SEG_W-1:0] seg_encode(input digit_t d);
      return d.blank ? SEG_BLANK : SEG_TABLE[d.nib];
   endfunction

endpackage

// File: rtl/result_display_driver_if.sv
// Result bus consumer interface: load strobe in, busy and display lines out.
interface result_display_driver_if;
   import result_display_driver_pkg::*;

   logic             load;
   logic [VAL_W-1:0] value;
   logic             hex_mode;
   logic             busy;
   logic [AN_W-1:0]  an;
   logic [SEG_W-1:0] seg;
   logic             dp;

   modport master (output load, value, hex_mode, input busy, an, seg, dp);
   modport slave  (input load, value, hex_mode, output busy, an, seg, dp);

endinterface

// File: rtl/result_display_driver_bin_to_bcd_step.sv
// One combinational double-dabble iteration over the {bcd, bin} register.
module bin_to_bcd_step
   import result_display_driver_pkg::*;
(
   input  logic [DD_W-1:0] i_dd,
   output logic [DD_W-1:0] o_dd_c
);

   logic [DD_W-1:0] w_adj;

   always_comb begin
      w_adj = i_dd;
      for (int i = 0; i < int'(BCD_W / NIB_W); i++) begin
         if (i_dd[VAL_W + NIB_W*i +: NIB_W] >= 4'd5) begin
            w_adj[VAL_W + NIB_W*i +: NIB_W] = i_dd[VAL_W + NIB_W*i +: NIB_W] + 4'd3;
         end
      end
   end

   assign o_dd_c = {w_adj[DD_W-2:0], 1'b0};

endmodule

// File: rtl/result_display_driver.sv
// Captures a result, converts it to decimal (or passes hex) and scans it
// onto a 4-digit active-low common-anode seven-segment display.
module result_display_driver
   import result_display_driver_pkg::*;
#(
   parameter int unsigned REFRESH_BITS = 17
)(
   input  logic                    clk,
   input  logic                    rst_n,
   result_display_driver_if.slave  bus
);

   state_e              r_state, w_state_nxt;
   logic [DD_W-1:0]     r_shift;
   logic [ITER_W-1:0]   r_iter;
   digit_t              r_dig2, r_dig1, r_dig0;
   logic                r_pend, r_pend_hex;
   logic [VAL_W-1:0]    r_pend_val;
   logic [REFRESH_BITS-1:0] r_scan;
   logic [AN_W-1:0]     r_an;
   logic [SEG_W-1:0]    r_seg;
   logic                r_dp, r_busy;

   logic                w_start, w_start_hex, w_step;
   logic [VAL_W-1:0]    w_start_val;
   logic                w_commit_dec, w_commit_hex, w_pend_set, w_pend_clr;
   logic [DD_W-1:0]     w_step_out;
   logic [NIB_W-1:0]    w_hund, w_tens, w_unit;
   logic [1:0]          w_sel;
   digit_t              w_sel_dig;

   bin_to_bcd_step u_step (
      .i_dd   (r_shift),
      .o_dd_c (w_step_out)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and control strobes; CONV holds one extra cycle after the
   // eighth iteration so a pending request is taken from a clean IDLE cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_start_val  = bus.value;
      w_start_hex  = bus.hex_mode;
      w_step       = 1'b0;
      w_commit_dec = 1'b0;
      w_commit_hex = 1'b0;
      w_pend_set   = 1'b0;
      w_pend_clr   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.load) begin
               w_start    = 1'b1;
               w_pend_clr = 1'b1;
            end else if (r_pend) begin
               w_start     = 1'b1;
               w_start_val = r_pend_val;
               w_start_hex = r_pend_hex;
               w_pend_clr  = 1'b1;
            end
            if (w_start) w_state_nxt = w_start_hex ? ST_HEXLD : ST_CONV;
         end
         ST_CONV: begin
            w_pend_set = bus.load;
            if (r_iter == ITER_W'(VAL_W)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_step       = 1'b1;
               w_commit_dec = (r_iter == ITER_W'(VAL_W - 1));
            end
         end
         ST_HEXLD: begin
            w_pend_set   = bus.load;
            w_commit_hex = 1'b1;
            w_state_nxt  = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Conversion datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_iter  <= '0;
      end else if (w_start) begin
         r_shift <= {BCD_W'(0), w_start_val};
         r_iter  <= '0;
      end else if (w_step) begin
         r_shift <= w_step_out;
         r_iter  <= r_iter + ITER_W'(1);
      end
   end

   // One-deep pending request, latest wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= 1'b0;
         r_pend_val <= '0;
         r_pend_hex <= 1'b0;
      end else if (w_pend_clr) begin
         r_pend <= 1'b0;
      end else if (w_pend_set) begin
         r_pend     <= 1'b1;
         r_pend_val <= bus.value;
         r_pend_hex <= bus.hex_mode;
      end
   end

   assign w_hund = w_step_out[DD_W-1 -: NIB_W];
   assign w_tens = w_step_out[DD_W-NIB_W-1 -: NIB_W];
   assign w_unit = w_step_out[VAL_W +: NIB_W];

   // Shown digits only change on commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dig2 <= DIGIT_BLANK;
         r_dig1 <= DIGIT_BLANK;
         r_dig0 <= DIGIT_BLANK;
      end else if (w_commit_dec) begin
         r_dig2 <= (w_hund == '0) ? DIGIT_BLANK : mk_digit(w_hund);
         r_dig1 <= ((w_hund == '0) && (w_tens == '0)) ? DIGIT_BLANK : mk_digit(w_tens);
         r_dig0 <= mk_digit(w_unit);
      end else if (w_commit_hex) begin
         r_dig2 <= DIGIT_BLANK;
         r_dig1 <= mk_digit(r_shift[VAL_W-1 -: NIB_W]);
         r_dig0 <= mk_digit(r_shift[NIB_W-1:0]);
      end
   end

   assign w_sel = r_scan[REFRESH_BITS-1 -: 2];

   always_comb begin
      w_sel_dig = DIGIT_BLANK;
      unique case (w_sel)
         2'd0:    w_sel_dig = r_dig0;
         2'd1:    w_sel_dig = r_dig1;
         2'd2:    w_sel_dig = r_dig2;
         default: w_sel_dig = DIGIT_BLANK;
      endcase
   end

   // Scan counter and registered display drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan <= '0;
         r_an   <= '1;
         r_seg  <= SEG_BLANK;
         r_dp   <= 1'b1;
         r_busy <= 1'b0;
      end else begin
         r_scan <= r_scan + REFRESH_BITS'(1);
         r_an   <= ~(AN_W'(1) << w_sel);
         r_seg  <= seg_encode(w_sel_dig);
         r_dp   <= 1'b1;
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   assign bus.busy = r_busy;
   assign bus.an   = r_an;
   assign bus.seg  = r_seg;
   assign bus.dp   = r_dp;

endmodule

// File: tb/tb_result_display_driver.sv
// Self-checking bench for result_display_driver: vector table, random loads
// against a decimal/hex display model, and pending/reset sequences.
module tb_result_display_driver;

   localparam int RB       = 6;
   localparam int SCAN_LEN = 1 << RB;
   localparam int SLOT     = SCAN_LEN / 4;

   typedef struct {
      logic [7:0]      val;
      bit              hex;
      int              busy_cyc;
      logic [3:0][6:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [6:0] seg_tab [16];
   vec_t tab [9];

   result_display_driver_if bus ();

   result_display_driver #(.REFRESH_BITS(RB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: what each of the four positions should show for a value
   function automatic logic [3:0][6:0] model_segs(input int v, input bit h);
      int d [4];
      int hu, te;
      logic [3:0][6:0] r;
      d[3] = -1;
      if (h) begin
         d[2] = -1;
         d[1] = v / 16;
         d[0] = v % 16;
      end else begin
         hu   = v / 100;
         te   = (v / 10) % 10;
         d[2] = (hu == 0) ? -1 : hu;
         d[1] = (hu == 0 && te == 0) ? -1 : te;
         d[0] = v % 10;
      end
      for (int p = 0; p < 4; p++) r[p] = (d[p] < 0) ? 7'h7F : seg_tab[d[p]];
      return r;
   endfunction

   task automatic do_load(input logic [7:0] v, input bit h, output int nb);
      @(negedge clk);
      bus.load = 1'b1; bus.value = v; bus.hex_mode = h;
      @(posedge clk); #1;
      bus.load = 1'b0;
      nb = 0;
      while (bus.busy === 1'b1 && nb < 20) begin
         nb++;
         @(posedge clk); #1;
      end
   endtask

   // Observe one full scan period and compare each position's glyph
   task automatic scan_check(input string name, input logic [3:0][6:0] exp);
      int bad;
      int sel;
      logic [3:0] ean;
      logic [6:0] obs [4];
      bad = 0;
      for (int p = 0; p < 4; p++) obs[p] = 7'bx;
      repeat (SCAN_LEN) begin
         @(posedge clk); #1;
         sel = ((cyc - 1) % SCAN_LEN) / SLOT;
         ean = 4'b1111 ^ (4'(1) << sel);
         if (bus.an !== ean || bus.dp !== 1'b1) bad++;
         obs[sel] = bus.seg;
      end
      check({name, "_scan"}, bad, 0);
      for (int p = 0; p < 4; p++) check($sformatf("%s_dig%0d", name, p), {25'd0, obs[p]}, {25'd0, exp[p]});
   endtask

   initial begin
      int nb;
      int bad;
      logic [7:0] rv;
      bit rh;
      bit exp_b;

      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      tab[0] = '{8'd255, 1'b0, 9, {7'h7F, 7'h24, 7'h12, 7'h12}};
      tab[1] = '{8'd7,   1'b0, 9, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
      tab[2] = '{8'd0,   1'b0, 9, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      tab[3] = '{8'hA5,  1'b1, 1, {7'h7F, 7'h7F, 7'h08, 7'h12}};
      tab[4] = '{8'h05,  1'b1, 1, {7'h7F, 7'h7F, 7'h40, 7'h12}};
      tab[5] = '{8'd100, 1'b0, 9, {7'h7F, 7'h79, 7'h40, 7'h40}};
      tab[6] = '{8'd10,  1'b0, 9, {7'h7F, 7'h7F, 7'h79, 7'h40}};
      tab[7] = '{8'd99,  1'b0, 9, {7'h7F, 7'h7F, 7'h10, 7'h10}};
      tab[8] = '{8'hFF,  1'b1, 1, {7'h7F, 7'h7F, 7'h0E, 7'h0E}};

      bus.load = 1'b0; bus.value = 8'd0; bus.hex_mode = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_an",   bus.an,   4'hF);
      check("rst_seg",  bus.seg,  7'h7F);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_dp",   bus.dp,   1'b1);
      @(negedge clk) rst_n = 1'b1;
      scan_check("idle", {4{7'h7F}});

      for (int i = 0; i < 9; i++) begin
         do_load(tab[i].val, tab[i].hex, nb);
         check($sformatf("vec%0d_busy", i), nb, tab[i].busy_cyc);
         scan_check($sformatf("vec%0d", i), tab[i].exp);
      end

      for (int i = 0; i < 12; i++) begin
         rv = 8'($urandom_range(0, 255));
         rh = 1'($urandom_range(0, 1));
         do_load(rv, rh, nb);
         check($sformatf("rnd%0d_busy", i), nb, rh ? 1 : 9);
         scan_check($sformatf("rnd%0d_v%0d_h%0d", i, rv, rh), model_segs(int'(rv), rh));
      end

      // Loads during a conversion: 42 is overwritten by 99, which starts
      // from the IDLE cycle after the first conversion finishes.
      @(negedge clk); bus.load = 1'b1; bus.value = 8'd100; bus.hex_mode = 1'b0;
      @(posedge clk); #1; bus.load = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); bus.load = 1'b1; bus.value = 8'd42;
      @(posedge clk); #1; bus.load = 1'b0;
      @(posedge clk);
      @(negedge clk); bus.load = 1'b1; bus.value = 8'd99;
      @(posedge clk); #1; bus.load = 1'b0;
      bad = 0;
      for (int k = 6; k <= 25; k++) begin
         @(posedge clk); #1;
         exp_b = (k <= 8) || (k >= 10 && k <= 18);
         if (bus.busy !== exp_b) bad++;
      end
      check("pend_busy_trace", bad, 0);
      scan_check("pend", model_segs(99, 1'b0));

      // Reset mid-conversion, with a pending request queued
      @(negedge clk); bus.load = 1'b1; bus.value = 8'd200; bus.hex_mode = 1'b0;
      @(posedge clk); #1; bus.load = 1'b0;
      @(posedge clk);
      @(negedge clk); bus.load = 1'b1; bus.value = 8'd55;
      @(posedge clk); #1; bus.load = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_an",   bus.an,   4'hF);
      check("mid_rst_seg",  bus.seg,  7'h7F);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_dp",   bus.dp,   1'b1);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_busy", bus.busy, 1'b0);
      scan_check("post_rst", {4{7'h7F}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
